// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_pipe.sv
// Pipelined multi-channel wide NOR (zero-detect) built from a registered 3-ary OR tree.
// Latency: LEVELS = max(1, ceil(log3(WIDTH))) enabled cycles from A/VLD_I to ZN/VLD_O.
// Backpressure: EN=0 freezes every register (data, valid, ZN); inputs are ignored while stalled.
// Optional sticky zero flag (CLR, ZN_STKY) is built when GF180_NOR_PIPE_STICKY_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0__nor_pipe #(
    parameter int WIDTH = 9,
    parameter int CH    = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                VLD_I,
    input  logic [CH*WIDTH-1:0] A,
`ifdef GF180_NOR_PIPE_STICKY_EN
    input  logic                CLR,
    output logic [CH-1:0]       ZN_STKY,
`endif
    output logic                VLD_O,
    output logic [CH-1:0]       ZN,
    inout  wire                 VDD,
    inout  wire                 VSS
);

    function automatic int calc_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 1) begin
            n = (n + 2) / 3;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    function automatic int nodes_at(input int w, input int k);
        int n;
        n = w;
        for (int i = 0; i < k; i++) n = (n + 2) / 3;
        return n;
    endfunction

    function automatic int offset_at(input int w, input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o += nodes_at(w, i);
        return o;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);
    // Each channel keeps levels 0..LEVELS-1 packed back to back; level 0 is A itself.
    localparam int TOT    = offset_at(WIDTH, LEVELS);
    localparam int NR     = nodes_at(WIDTH, LEVELS - 1);
    localparam int OR_OFS = offset_at(WIDTH, LEVELS - 1);

    logic [CH-1:0]     zn_d;
    logic [CH-1:0]     zn_q;
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS-1:0] vld_q;

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            logic [TOT-1:0] lvl;
            logic [2:0]     root_child;

            assign lvl[WIDTH-1:0] = A[c*WIDTH +: WIDTH];

            for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
                localparam int NP = nodes_at(WIDTH, k - 1);
                localparam int N  = nodes_at(WIDTH, k);
                localparam int OP = offset_at(WIDTH, k - 1);
                localparam int O  = offset_at(WIDTH, k);

                logic [3*N-1:0] child;
                logic [N-1:0]   node_d;
                logic [N-1:0]   node_q;

                // Children beyond the previous level's width are tied low.
                always_comb begin
                    child          = '0;
                    child[NP-1:0]  = lvl[OP +: NP];
                    node_d         = '0;
                    for (int j = 0; j < N; j++) begin
                        node_d[j] = |child[3*j +: 3];
                    end
                end

                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        node_q <= '0;
                    end else if (EN) begin
                        node_q <= node_d;
                    end
                end

                assign lvl[O +: N] = node_q;
            end

            always_comb begin
                root_child         = '0;
                root_child[NR-1:0] = lvl[OR_OFS +: NR];
            end

            assign zn_d[c] = ~|root_child;
        end
    endgenerate

    always_comb begin
        vld_d    = '0;
        vld_d[0] = VLD_I;
        for (int i = 1; i < LEVELS; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= '0;
            zn_q  <= '1;
        end else if (EN) begin
            vld_q <= vld_d;
            zn_q  <= zn_d;
        end
    end

    assign VLD_O = vld_q[LEVELS-1];
    assign ZN    = zn_q;

`ifdef GF180_NOR_PIPE_STICKY_EN
    logic [CH-1:0] stky_set;
    logic [CH-1:0] stky_d;
    logic [CH-1:0] stky_q;

    // Set is evaluated on the values about to load into ZN/VLD_O, so it wins over CLR.
    always_comb begin
        stky_set = (EN && vld_d[LEVELS-1]) ? zn_d : '0;
        stky_d   = CLR ? '0 : stky_q;
        stky_d   = stky_d | stky_set;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stky_q <= '0;
        end else begin
            stky_q <= stky_d;
        end
    end

    assign ZN_STKY = stky_q;
`endif

    wire unused_supply;
    assign unused_supply = VDD ^ VSS;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor_pipe.sv
// Bench for the pipelined wide NOR: WIDTH=9/CH=2 (LEVELS=2) and WIDTH=10/CH=1 (LEVELS=3) instances.
module tb_gf180mcu_fd_sc_mcu7t5v0__nor_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        v9_i;
    logic [17:0] a9;
    logic        v9_o;
    logic [1:0]  zn9;
    logic        v10_i;
    logic [9:0]  a10;
    logic        v10_o;
    logic [0:0]  zn10;
    wire         vdd = 1'b1;
    wire         vss = 1'b0;
`ifdef GF180_NOR_PIPE_STICKY_EN
    logic        clr;
    logic [1:0]  stky9;
    logic [0:0]  unused_stky10;
`endif

    gf180mcu_fd_sc_mcu7t5v0__nor_pipe #(.WIDTH(9), .CH(2)) u9 (
        .CLK(clk), .RST(rst), .EN(en), .VLD_I(v9_i), .A(a9),
`ifdef GF180_NOR_PIPE_STICKY_EN
        .CLR(clr), .ZN_STKY(stky9),
`endif
        .VLD_O(v9_o), .ZN(zn9), .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu7t5v0__nor_pipe #(.WIDTH(10), .CH(1)) u10 (
        .CLK(clk), .RST(rst), .EN(en), .VLD_I(v10_i), .A(a10),
`ifdef GF180_NOR_PIPE_STICKY_EN
        .CLR(clr), .ZN_STKY(unused_stky10),
`endif
        .VLD_O(v10_o), .ZN(zn10), .VDD(vdd), .VSS(vss)
    );

    int         checks = 0;
    int         errors = 0;
    logic [1:0] q9[$];
    logic       q10[$];
    logic       adv = 1'b0;
    logic [1:0] e9;
    logic       e10;

    typedef struct { logic [17:0] a; logic v; logic [1:0] zn; } vec9_t;
    typedef struct { logic [9:0]  a; logic v; logic      zn; } vec10_t;
    vec9_t  t9[10];
    vec10_t t10[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put9(input logic [17:0] a, input logic v, input logic [1:0] e);
        a9   = a;
        v9_i = v;
        if (v && en) q9.push_back(e);
    endtask

    task automatic put10(input logic [9:0] a, input logic v, input logic e);
        a10   = a;
        v10_i = v;
        if (v && en) q10.push_back(e);
    endtask

    // An output is new only if the preceding edge was enabled and out of reset.
    always @(posedge clk) adv <= en && !rst;

    always @(negedge clk) begin
        if (!rst && adv && v9_o) begin
            if (q9.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb9_unexpected: VLD_O=1 zn=%0h with no sample pending", zn9);
            end else begin
                e9 = q9.pop_front();
                chk("sb9_zn", {30'd0, zn9}, {30'd0, e9});
            end
        end
        if (!rst && adv && v10_o) begin
            if (q10.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb10_unexpected: VLD_O=1 zn=%0h with no sample pending", zn10);
            end else begin
                e10 = q10.pop_front();
                chk("sb10_zn", {31'd0, zn10}, {31'd0, e10});
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [17:0] ra;

        t9[0] = '{18'h00000, 1'b1, 2'b11};
        t9[1] = '{18'h00100, 1'b1, 2'b10};
        t9[2] = '{18'h20000, 1'b1, 2'b01};
        t9[3] = '{18'h00001, 1'b1, 2'b10};
        t9[4] = '{18'h00200, 1'b1, 2'b01};
        t9[5] = '{18'h3FFFF, 1'b1, 2'b00};
        t9[6] = '{18'h1FF00, 1'b0, 2'b00};
        t9[7] = '{18'h0A0A0, 1'b1, 2'b00};
        t9[8] = '{18'h3FE00, 1'b1, 2'b01};
        t9[9] = '{18'h001FF, 1'b1, 2'b10};
        t10[0] = '{10'h200, 1'b1, 1'b0};
        t10[1] = '{10'h000, 1'b1, 1'b1};
        t10[2] = '{10'h001, 1'b1, 1'b0};
        t10[3] = '{10'h080, 1'b1, 1'b0};
        t10[4] = '{10'h3FF, 1'b1, 1'b0};
        t10[5] = '{10'h000, 1'b1, 1'b1};

        rst = 1'b0; en = 1'b1; v9_i = 1'b0; a9 = '0; v10_i = 1'b0; a10 = '0;
`ifdef GF180_NOR_PIPE_STICKY_EN
        clr = 1'b0;
`endif
        #1 rst = 1'b1;
        #1;
        chk("rst_vld9", {31'd0, v9_o}, 32'd0);
        chk("rst_zn9", {30'd0, zn9}, 32'd3);
        chk("rst_vld10", {31'd0, v10_o}, 32'd0);
        chk("rst_zn10", {31'd0, zn10}, 32'd1);
`ifdef GF180_NOR_PIPE_STICKY_EN
        chk("rst_stky9", {30'd0, stky9}, 32'd0);
`endif
        cyc(1);
        rst = 1'b0;

        // Latency and function, WIDTH=9 CH=2.
        put9(18'h00000, 1'b1, 2'b11);
        cyc(1); chk("lat_first_edge_vld", {31'd0, v9_o}, 32'd0);
        put9(18'h00100, 1'b1, 2'b10);
        cyc(1); chk("lat_vld_rise", {31'd0, v9_o}, 32'd1); chk("lat_zn0", {30'd0, zn9}, 32'd3);
        put9(18'h20000, 1'b1, 2'b01);
        cyc(1); chk("lat_zn1", {30'd0, zn9}, 32'd2);
        put9(18'h00000, 1'b0, 2'b00);
        cyc(1); chk("lat_zn2", {30'd0, zn9}, 32'd1); chk("lat_zn2_vld", {31'd0, v9_o}, 32'd1);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2 rst = 1'b1; q9.delete(); q10.delete();
        #1;
        chk("arst_vld9", {31'd0, v9_o}, 32'd0);
        chk("arst_zn9", {30'd0, zn9}, 32'd3);
        cyc(1); rst = 1'b0;
        cyc(1); chk("rel_first_edge_vld", {31'd0, v9_o}, 32'd0);

        // Table vectors through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            put9(t9[i].a, t9[i].v, t9[i].zn);
            cyc(1);
        end
        put9(18'h00000, 1'b0, 2'b00);
        cyc(3);

        // Random vectors with per-channel zero masking, checked against a flat NOR model.
        for (int i = 0; i < 12; i++) begin
            r  = $urandom;
            ra = r[17:0] & r[31:14];
            if (r[0]) ra[8:0] = 9'd0;
            if (r[1]) ra[17:9] = 9'd0;
            put9(ra, 1'b1, {~|ra[17:9], ~|ra[8:0]});
            cyc(1);
        end
        put9(18'h00000, 1'b0, 2'b00);
        cyc(3);

        // Padding, WIDTH=10 LEVELS=3.
        put10(10'h200, 1'b1, 1'b0);
        cyc(1); chk("pad_e1_vld", {31'd0, v10_o}, 32'd0);
        put10(10'h000, 1'b1, 1'b1);
        cyc(1); chk("pad_e2_vld", {31'd0, v10_o}, 32'd0);
        put10(10'h000, 1'b0, 1'b0);
        cyc(1); chk("pad_e3_vld", {31'd0, v10_o}, 32'd1); chk("pad_hi_bit_zn", {31'd0, zn10}, 32'd0);
        cyc(1); chk("pad_zero_zn", {31'd0, zn10}, 32'd1);
        cyc(1); chk("pad_drain_vld", {31'd0, v10_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            put10(t10[i].a, t10[i].v, t10[i].zn);
            cyc(1);
        end
        put10(10'h000, 1'b0, 1'b0);
        cyc(4);

        // Stall: output and in-flight sample frozen while A toggles.
        put9(18'h00000, 1'b1, 2'b11);
        cyc(1);
        put9(18'h00100, 1'b1, 2'b10);
        cyc(1);
        chk("stall_pre_vld", {31'd0, v9_o}, 32'd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r    = $urandom;
            a9   = r[17:0] | 18'h00001;
            v9_i = 1'b1;
            cyc(1);
            chk("stall_hold_vld", {31'd0, v9_o}, 32'd1);
            chk("stall_hold_zn", {30'd0, zn9}, 32'd3);
        end
        en = 1'b1;
        put9(18'h00000, 1'b0, 2'b00);
        cyc(1); chk("stall_resume_vld", {31'd0, v9_o}, 32'd1); chk("stall_resume_zn", {30'd0, zn9}, 32'd2);
        cyc(1); chk("stall_no_dup", {31'd0, v9_o}, 32'd0);

        // Reset with two samples in flight in the LEVELS=3 pipe.
        put10(10'h001, 1'b1, 1'b0);
        cyc(1);
        put10(10'h000, 1'b1, 1'b1);
        cyc(1); chk("rms_pre_vld", {31'd0, v10_o}, 32'd0);
        put10(10'h000, 1'b0, 1'b0);
        #2 rst = 1'b1; q9.delete(); q10.delete();
        #1 chk("rms_arst_vld", {31'd0, v10_o}, 32'd0);
        cyc(1);
        rst = 1'b0;
        put10(10'h200, 1'b1, 1'b0);
        cyc(1); chk("rms_e1_vld", {31'd0, v10_o}, 32'd0);
        put10(10'h000, 1'b0, 1'b0);
        cyc(1); chk("rms_e2_vld", {31'd0, v10_o}, 32'd0);
        cyc(1); chk("rms_e3_vld", {31'd0, v10_o}, 32'd1); chk("rms_e3_zn", {31'd0, zn10}, 32'd0);
        cyc(1); chk("rms_after_vld", {31'd0, v10_o}, 32'd0);

`ifdef GF180_NOR_PIPE_STICKY_EN
        #2 rst = 1'b1; q9.delete(); q10.delete();
        #1 chk("stky_rst", {30'd0, stky9}, 32'd0);
        cyc(1);
        rst = 1'b0;
        put9(18'h3FE00, 1'b1, 2'b01);
        cyc(1); put9(18'h00000, 1'b0, 2'b00);
        cyc(1); chk("stky_set", {30'd0, stky9}, 32'd1);
        put9(18'h3FE01, 1'b1, 2'b00);
        cyc(1); put9(18'h00000, 1'b0, 2'b00);
        cyc(1); chk("stky_keep", {30'd0, stky9}, 32'd1);
        clr = 1'b1;
        cyc(1); clr = 1'b0; chk("stky_clr", {30'd0, stky9}, 32'd0);
        put9(18'h3FE00, 1'b1, 2'b01);
        cyc(1); put9(18'h00000, 1'b0, 2'b00); clr = 1'b1;
        cyc(1); clr = 1'b0; chk("stky_set_wins", {30'd0, stky9}, 32'd1);
        en = 1'b0; clr = 1'b1;
        cyc(1); en = 1'b1; clr = 1'b0; chk("stky_clr_stalled", {30'd0, stky9}, 32'd0);
`endif

        cyc(4);
        chk("sb9_drained", q9.size(), 32'd0);
        chk("sb10_drained", q10.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__nor_pipe.md
Name: gf180mcu_fd_sc_mcu7t5v0__nor_pipe

Overview:
- Parametrised, pipelined, multi-channel wide NOR: the registered successor to the 3-input NOR cell.
- Each channel reduces WIDTH inputs through a 3-ary OR tree with one register per tree level, and inverts at the output.
- Used for zero-detect on wide buses where a flat NOR would miss timing.
- Carries a valid pipeline and a global stall so it drops into streaming datapaths.

Parameters:
- WIDTH, 9, input bits per channel; legal range 1..243.
- CH, 1, number of independent channels; legal range 1..16.
- LEVELS, derived localparam, max(1, ceil(log3(WIDTH))); pipeline depth. Not overridable.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  pipeline advance; 0 = every register holds.
- VLD_I  input  1  qualifies A on this cycle.
- A  input  CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- VLD_O  output  1  ZN valid.
- ZN  output  CH  registered NOR of channel c inputs.
- VDD  inout  1  supply.
- VSS  inout  1  ground.

Behaviour:
- Reset: while RST=1, all tree registers are 0, the valid shift register is 0, VLD_O=0 and ZN={CH{1'b1}}. All are asynchronous and immediate. Release is synchronous to the next CLK edge.
- Tree structure:
  - Level k (1..LEVELS) holds ceil(WIDTH/3^k) nodes per channel.
  - Node j at level k = OR of children 3j, 3j+1, 3j+2 of level k-1; level 0 is A.
  - A missing child (WIDTH not a power of 3) is tied to 0.
  - Every level is registered.
- Output: ZN[c] is a flop loaded with ~(level LEVELS-1 root OR) on the edge that fills the last level. No combinational path from A to ZN.
  - For WIDTH<=3, LEVELS=1 and the single flop is ZN itself.
- Valid: VLD_I enters a LEVELS-deep shift register alongside data; VLD_O is its last stage.
- Latency: exactly LEVELS enabled cycles from a VLD_I/A sample to the matching VLD_O/ZN.
- Stall: when EN=0, all data and valid registers hold, including ZN and VLD_O. A and VLD_I are ignored that cycle.
- Data registers update on every enabled cycle regardless of VLD_I; only VLD_O qualifies ZN. Bubbles produce don't-care ZN with VLD_O=0.
- Channels are fully independent and share only CLK, RST, EN and the valid chain.
- Reset mid-stream: all in-flight samples are discarded. The first valid output after reset belongs to the first VLD_I sampled after release.
- Arithmetic: pure Boolean; no width growth.
- Supplies: VDD/VSS are connectivity-only; no behaviour depends on them.

Optional Feature:
- Macro: GF180_NOR_PIPE_STICKY_EN.
- When defined, the block adds:
  - input CLR (1 bit), synchronous clear.
  - output ZN_STKY (CH bits), reset 0.
- ZN_STKY[c] sets to 1 on any enabled edge where the newly loaded VLD_O=1 and ZN[c]=1, i.e. a valid all-zero sample emerges.
- CLR=1 clears ZN_STKY on the edge, independent of EN.
- If set and clear occur on the same edge, set wins.
- When not defined, CLR and ZN_STKY do not exist, and no sticky logic is present.

Test Plan:
1. Reset: WIDTH=9, CH=2, RST pulsed mid-cycle -> VLD_O=0 and ZN=2'b11 immediately, with no clock needed. First edge after release keeps VLD_O=0.
2. Latency/function: WIDTH=9, CH=2, EN=1; drive VLD_I=1 on three consecutive cycles with A = 18'h0, then 18'h00100, then 18'h20000.
   - VLD_O rises 2 cycles after the first sample.
   - ZN sequence is 2'b11, then 2'b10, then 2'b01.
3. Padding: WIDTH=10 (LEVELS=3), A=10'h200 -> ZN=0 after 3 cycles. A=10'h000 -> ZN=1.
4. Stall: EN=0 for 4 cycles while A toggles -> ZN and VLD_O frozen. On EN=1, the in-flight results resume in order with no loss or duplication.
5. Reset mid-stream: assert RST with 2 samples in flight -> neither sample appears. A new sample 1 cycle after release yields VLD_O at release+LEVELS cycles.
6. Sticky (macro defined): a valid A=0 sets ZN_STKY[0]. A later nonzero sample keeps it set. CLR clears it. CLR coincident with a new valid zero -> ZN_STKY stays 1.
